// File: rtl/writeback_stage.sv
// Writeback stage: load-lane extraction/extension, register-file write pulse and forwarding tap.
// Optional retired-instruction counter is built only when WB_RETIRE_COUNT_EN is defined.
module writeback_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              d_clk,
    input  logic              d_rst,
    input  logic              wb_i_ce,
    input  logic              wb_i_stall,
    input  logic              wb_i_flush,
    input  logic              wb_i_regwrite,
    input  logic              wb_i_memtoreg,
    input  logic [AWIDTH-1:0] wb_i_rd_addr,
    input  logic [DWIDTH-1:0] wb_i_alu_value,
    input  logic [DWIDTH-1:0] wb_i_load_data,
    input  logic [1:0]        wb_i_load_size,
    input  logic              wb_i_load_unsigned,
    output logic              wb_o_we,
    output logic [AWIDTH-1:0] wb_o_rd_addr,
    output logic [DWIDTH-1:0] wb_o_data,
    output logic              wb_o_fwd_valid,
    output logic [AWIDTH-1:0] wb_o_fwd_addr,
    output logic [DWIDTH-1:0] wb_o_fwd_data,
    output logic              wb_o_misalign,
    output logic [31:0]       wb_o_retired
);

    logic [1:0]        offset;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DWIDTH-1:0] load_ext;
    logic [DWIDTH-1:0] result;
    logic              misaligned;
    logic              capture;
    logic              write_ok;

    logic              we_q;
    logic              mis_q;
    logic              fwd_valid_q;
    logic [AWIDTH-1:0] rd_q;
    logic [DWIDTH-1:0] data_q;

    assign offset  = wb_i_alu_value[1:0];
    assign capture = wb_i_ce & ~wb_i_stall & ~wb_i_flush;

    always_comb begin
        byte_lane = 8'h00;
        case (offset)
            2'd0: byte_lane = wb_i_load_data[7:0];
            2'd1: byte_lane = wb_i_load_data[15:8];
            2'd2: byte_lane = wb_i_load_data[23:16];
            default: byte_lane = wb_i_load_data[31:24];
        endcase
        half_lane = offset[1] ? wb_i_load_data[31:16] : wb_i_load_data[15:0];
    end

    always_comb begin
        load_ext   = wb_i_load_data;
        misaligned = 1'b0;
        case (wb_i_load_size)
            2'b00: begin
                load_ext = wb_i_load_unsigned ? {{(DWIDTH-8){1'b0}}, byte_lane}
                                              : {{(DWIDTH-8){byte_lane[7]}}, byte_lane};
            end
            2'b01: begin
                load_ext   = wb_i_load_unsigned ? {{(DWIDTH-16){1'b0}}, half_lane}
                                                : {{(DWIDTH-16){half_lane[15]}}, half_lane};
                misaligned = offset[0];
            end
            default: begin
                load_ext   = wb_i_load_data;
                misaligned = (offset != 2'b00);
            end
        endcase
        // ALU results bypass the load path entirely, so they can never be misaligned.
        if (!wb_i_memtoreg) begin
            load_ext   = wb_i_alu_value;
            misaligned = 1'b0;
        end
        result = load_ext;
    end

    assign write_ok = wb_i_regwrite & (|wb_i_rd_addr) & ~misaligned;

    // Flush outranks stall, stall outranks capture; pulses never repeat while held.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            fwd_valid_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else if (wb_i_flush) begin
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            fwd_valid_q <= 1'b0;
        end else if (wb_i_stall) begin
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
        end else if (wb_i_ce) begin
            we_q        <= write_ok;
            mis_q       <= misaligned;
            fwd_valid_q <= write_ok;
            rd_q        <= wb_i_rd_addr;
            data_q      <= result;
        end else begin
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            fwd_valid_q <= 1'b0;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            retired_q <= 32'd0;
        end else if (capture) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign wb_o_retired = retired_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign wb_o_retired   = 32'd0;
`endif

    assign wb_o_we        = we_q;
    assign wb_o_misalign  = mis_q;
    assign wb_o_rd_addr   = rd_q;
    assign wb_o_data      = data_q;
    assign wb_o_fwd_valid = fwd_valid_q;
    assign wb_o_fwd_addr  = rd_q;
    assign wb_o_fwd_data  = data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver pushes the expected next-cycle outputs,
// a monitor pops one entry per clock and compares. Counter checks follow WB_RETIRE_COUNT_EN.
module tb_writeback_stage;

    logic        d_clk;
    logic        d_rst;
    logic        wb_i_ce;
    logic        wb_i_stall;
    logic        wb_i_flush;
    logic        wb_i_regwrite;
    logic        wb_i_memtoreg;
    logic [4:0]  wb_i_rd_addr;
    logic [31:0] wb_i_alu_value;
    logic [31:0] wb_i_load_data;
    logic [1:0]  wb_i_load_size;
    logic        wb_i_load_unsigned;
    logic        wb_o_we;
    logic [4:0]  wb_o_rd_addr;
    logic [31:0] wb_o_data;
    logic        wb_o_fwd_valid;
    logic [4:0]  wb_o_fwd_addr;
    logic [31:0] wb_o_fwd_data;
    logic        wb_o_misalign;
    logic [31:0] wb_o_retired;

    writeback_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
        .d_clk(d_clk), .d_rst(d_rst),
        .wb_i_ce(wb_i_ce), .wb_i_stall(wb_i_stall), .wb_i_flush(wb_i_flush),
        .wb_i_regwrite(wb_i_regwrite), .wb_i_memtoreg(wb_i_memtoreg),
        .wb_i_rd_addr(wb_i_rd_addr), .wb_i_alu_value(wb_i_alu_value),
        .wb_i_load_data(wb_i_load_data), .wb_i_load_size(wb_i_load_size),
        .wb_i_load_unsigned(wb_i_load_unsigned),
        .wb_o_we(wb_o_we), .wb_o_rd_addr(wb_o_rd_addr), .wb_o_data(wb_o_data),
        .wb_o_fwd_valid(wb_o_fwd_valid), .wb_o_fwd_addr(wb_o_fwd_addr),
        .wb_o_fwd_data(wb_o_fwd_data), .wb_o_misalign(wb_o_misalign),
        .wb_o_retired(wb_o_retired)
    );

    // Expected visible state after one clock: we, misalign, fwd_valid, rd, data, retired.
    typedef struct packed {
        logic        we;
        logic        mis;
        logic        fwd;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference state: what the register file side should currently see.
    logic        m_we, m_mis, m_fwd;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_ret;

    // ---------------- clock / reset ----------------
    initial d_clk = 1'b0;
    always #5 d_clk = ~d_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_retired(input logic [31:0] model_count);
`ifdef WB_RETIRE_COUNT_EN
        return model_count;
`else
        return (model_count & 32'd0);
`endif
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] load_value(input logic [31:0] load, input logic [31:0] alu,
                                              input logic [1:0] size, input logic uns);
        int unsigned off;
        logic [31:0] v;
        off = alu % 4;
        if (size == 2'b00) begin
            v = (load >> (off * 8)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'b01) begin
            v = (load >> ((off / 2) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = load;
        end
        return v;
    endfunction

    function automatic logic is_misaligned(input logic memtoreg, input logic [31:0] alu,
                                           input logic [1:0] size);
        int unsigned off;
        off = alu % 4;
        if (!memtoreg) return 1'b0;
        if (size == 2'b01) return (off % 2) == 1;
        if (size[1]) return off != 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_we = 0; m_mis = 0; m_fwd = 0; m_rd = 0; m_data = 0; m_ret = 0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic ce, input logic stall, input logic flush,
                        input logic regwrite, input logic memtoreg, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] load,
                        input logic [1:0] size, input logic uns);
        exp_t e;
        logic mis, writes;
        @(negedge d_clk);
        wb_i_ce = ce; wb_i_stall = stall; wb_i_flush = flush;
        wb_i_regwrite = regwrite; wb_i_memtoreg = memtoreg; wb_i_rd_addr = rd;
        wb_i_alu_value = alu; wb_i_load_data = load; wb_i_load_size = size;
        wb_i_load_unsigned = uns;
        m_we = 0;
        m_mis = 0;
        if (flush) begin
            m_fwd = 0;
        end else if (stall) begin
            // held result and forwarding stay as they are
        end else if (ce) begin
            mis    = is_misaligned(memtoreg, alu, size);
            writes = regwrite && rd != 0 && !mis;
            m_data = memtoreg ? load_value(load, alu, size, uns) : alu;
            m_rd   = rd;
            m_we   = writes;
            m_fwd  = writes;
            m_mis  = mis;
            m_ret  = m_ret + 32'd1;
        end else begin
            m_fwd = 0;
        end
        e.we = m_we; e.mis = m_mis; e.fwd = m_fwd; e.rd = m_rd; e.data = m_data;
        e.ret = exp_retired(m_ret);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 2'b10, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge d_clk);
            n++;
        end
        @(negedge d_clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge d_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("we",        {31'd0, wb_o_we},        {31'd0, e.we});
                chk("misalign",  {31'd0, wb_o_misalign},  {31'd0, e.mis});
                chk("fwd_valid", {31'd0, wb_o_fwd_valid}, {31'd0, e.fwd});
                chk("rd_addr",   {27'd0, wb_o_rd_addr},   {27'd0, e.rd});
                chk("fwd_addr",  {27'd0, wb_o_fwd_addr},  {27'd0, e.rd});
                chk("data",      wb_o_data,               e.data);
                chk("fwd_data",  wb_o_fwd_data,           e.data);
                chk("retired",   wb_o_retired,            e.ret);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"},        {31'd0, wb_o_we},        32'd0);
        chk({tag, "_rd_addr"},   {27'd0, wb_o_rd_addr},   32'd0);
        chk({tag, "_data"},      wb_o_data,               32'd0);
        chk({tag, "_fwd_valid"}, {31'd0, wb_o_fwd_valid}, 32'd0);
        chk({tag, "_fwd_addr"},  {27'd0, wb_o_fwd_addr},  32'd0);
        chk({tag, "_fwd_data"},  wb_o_fwd_data,           32'd0);
        chk({tag, "_misalign"},  {31'd0, wb_o_misalign},  32'd0);
        chk({tag, "_retired"},   wb_o_retired,            32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        d_rst = 1'b0;
        wb_i_ce = 0; wb_i_stall = 0; wb_i_flush = 0; wb_i_regwrite = 0;
        wb_i_memtoreg = 0; wb_i_rd_addr = 0; wb_i_alu_value = 0;
        wb_i_load_data = 0; wb_i_load_size = 0; wb_i_load_unsigned = 0;
        model_reset();
        repeat (3) @(posedge d_clk);
        #1;
        check_all_zero("reset");
        @(negedge d_clk);
        d_rst = 1'b1;

        // word load, byte lanes with sign/zero extension
        step(1, 0, 0, 1, 1, 5'd8, 32'h100, 32'hDEADBEEF, 2'b10, 0);
        step(1, 0, 0, 1, 1, 5'd9, 32'h103, 32'h12345680, 2'b00, 0);
        step(1, 0, 0, 1, 1, 5'd9, 32'h100, 32'h12345680, 2'b00, 0);
        step(1, 0, 0, 1, 1, 5'd9, 32'h100, 32'h12345680, 2'b00, 1);
        step(1, 0, 0, 1, 1, 5'd10, 32'h102, 32'h8001FFFF, 2'b01, 0);
        step(1, 0, 0, 1, 1, 5'd10, 32'h100, 32'h8001FFFF, 2'b01, 1);
        // misaligned half and word, and a size=11 aligned word
        step(1, 0, 0, 1, 1, 5'd11, 32'h101, 32'hCAFEF00D, 2'b01, 0);
        step(1, 0, 0, 1, 1, 5'd11, 32'h102, 32'hCAFEF00D, 2'b11, 0);
        step(1, 0, 0, 1, 1, 5'd12, 32'h104, 32'hCAFEF00D, 2'b11, 0);
        // ALU pass-through ignores offset, then ce drop clears validity
        step(1, 0, 0, 1, 0, 5'd13, 32'hFFFF0003, 32'h0, 2'b01, 0);
        idle();
        // capture then 3 stalls, then flush
        step(1, 0, 0, 1, 0, 5'd3, 32'h55, 32'h0, 2'b10, 0);
        repeat (3) step(1, 1, 0, 1, 0, 5'd7, 32'h99, 32'h0, 2'b10, 0);
        step(1, 1, 1, 1, 0, 5'd7, 32'h99, 32'h0, 2'b10, 0);
        idle();
        // rd=0 never writes but still retires
        step(1, 0, 0, 1, 0, 5'd0, 32'h7, 32'h0, 2'b10, 0);
        idle();
        drain();

`ifdef WB_RETIRE_COUNT_EN
        // preload counter near its top to observe the wrap
        force dut.retired_q = 32'hFFFFFFFF;
        m_ret = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        step(1, 0, 0, 1, 0, 5'd0, 32'h7, 32'h0, 2'b10, 0);
        idle();
        drain();
`endif

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                 $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
        end
        drain();

        // reset asserted mid-cycle discards the pending capture
        wb_i_ce = 1; wb_i_stall = 0; wb_i_flush = 0; wb_i_regwrite = 1;
        wb_i_memtoreg = 0; wb_i_rd_addr = 5'd5; wb_i_alu_value = 32'h99;
        #2;
        d_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge d_clk);
        #1;
        check_all_zero("reset_hold");
        @(negedge d_clk);
        d_rst = 1'b1;
        model_reset();
        step(1, 0, 0, 1, 0, 5'd6, 32'h1234, 32'h0, 2'b10, 0);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DWIDTH, default 32, data word width.
REQ-002 Parameter AWIDTH, default 5, register-file address width.
REQ-003 d_clk  input  1  pipeline clock, rising-edge active.
REQ-004 d_rst  input  1  reset, asynchronous, active-low.
REQ-005 wb_i_ce  input  1  memory-stage result valid.
REQ-006 wb_i_stall  input  1  hold stage; no new capture.
REQ-007 wb_i_flush  input  1  kill the in-flight result.
REQ-008 wb_i_regwrite  input  1  instruction writes a register.
REQ-009 wb_i_memtoreg  input  1  1 = load data, 0 = ALU value.
REQ-010 wb_i_rd_addr  input  AWIDTH  destination register.
REQ-011 wb_i_alu_value  input  DWIDTH  execute-stage result or address.
REQ-012 wb_i_load_data  input  DWIDTH  raw word from data memory.
REQ-013 wb_i_load_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-014 wb_i_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
REQ-015 wb_o_we  output  1  register-file write enable.
REQ-016 wb_o_rd_addr  output  AWIDTH  register-file write address.
REQ-017 wb_o_data  output  DWIDTH  register-file write data.
REQ-018 wb_o_fwd_valid / wb_o_fwd_addr / wb_o_fwd_data  output  1/AWIDTH/DWIDTH  forwarding tap to decode.
REQ-019 wb_o_misalign  output  1  one-cycle pulse: misaligned load retired.
REQ-020 wb_o_retired  output  32  retired-instruction count.

Function
REQ-021 Capture on rising d_clk when wb_i_ce=1, wb_i_stall=0, wb_i_flush=0; outputs are registered, with 1-cycle latency from capture.
REQ-022 Byte offset is wb_i_alu_value[1:0]; byte load selects lane offset*8, half load selects lane offset[1]*16; then extends per wb_i_load_unsigned.
REQ-023 Misaligned = memtoreg and (half with offset[0]=1, or word/11 with offset!=0); misaligned loads set wb_o_misalign for one cycle and suppress wb_o_we.
REQ-024 wb_i_memtoreg=0 passes wb_i_alu_value unmodified; no misalign check.
REQ-025 wb_o_we is a single-cycle pulse in the cycle after capture, only when regwrite=1, rd_addr!=0, not misaligned.
REQ-026 Writes to register 0 never assert wb_o_we or wb_o_fwd_valid.
REQ-027 wb_i_stall=1: registered result, address, and fwd outputs hold; wb_o_we and wb_o_misalign are 0 during stall cycles (no repeated write).
REQ-028 wb_i_flush=1 has priority over ce and stall; the next cycle wb_o_we=0 and wb_o_fwd_valid=0, and the counter does not increment.
REQ-029 wb_o_fwd_valid=1 while the held result is valid, regwrite=1, rd!=0, and not misaligned; it stays asserted across stalls until replaced or flushed.
REQ-030 wb_i_ce=0 without stall: the valid bit clears next cycle, with no write.
REQ-031 wb_o_retired increments by 1 per capture (including misaligned and rd=0), and wraps from 0xFFFFFFFF to 0.

Reset
REQ-032 d_rst=0 asynchronously clears all registers: wb_o_we=0, wb_o_rd_addr=0, wb_o_data=0, fwd outputs 0, wb_o_misalign=0, wb_o_retired=0.
REQ-033 Reset mid-operation discards the in-flight result; first capture possible on the first rising edge with d_rst=1.

Configuration
REQ-034 Macro WB_RETIRE_COUNT_EN defined: the 32-bit counter per REQ-031 is built.
REQ-035 WB_RETIRE_COUNT_EN undefined: no counter flops; wb_o_retired tied to 0; all other behaviour identical.

Verification
REQ-036 Word load: memtoreg=1, size=10, alu=0x100, load=0xDEADBEEF, rd=8 -> next cycle we=1, addr=8, data=0xDEADBEEF.
REQ-037 Byte sign/zero: load=0x12345680, alu=0x103, size=00 -> data=0x00000012; alu=0x100, unsigned=0 -> data=0xFFFFFF80; unsigned=1 -> 0x00000080.
REQ-038 Misaligned half: size=01, alu=0x101 -> we=0, misalign=1 for one cycle, retired +1.
REQ-039 Stall/flush: capture ALU 0x55 rd=3, then stall 3 cycles -> one we pulse, fwd_valid=1 with data 0x55 throughout; then flush -> fwd_valid=0 next cycle.
REQ-040 rd=0 with regwrite=1, ALU 0x7 -> we=0, fwd_valid=0, retired +1; with counter preloaded to 0xFFFFFFFF -> wraps to 0.
